// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-4 stream demultiplexer.
// Optional build macro DEMUX_AUTO_SEL_EN selects round-robin steering.
package demux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic logic [NCH-1:0] onehot4(
        input logic [SEL_W-1:0] s
    );
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Two-bit wrapping destination pointer, advanced once per accepted beat.
// Only built when DEMUX_AUTO_SEL_EN is defined.
module demux_rr_ptr
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [SEL_W-1:0] ptr_o
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // Advance on enable; natural 2-bit overflow gives the 3->0 wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + SEL_W'(1);
        end
    end

    // Pointer register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_1in_4out.sv
// Registered 1-to-4 valid/ready demultiplexer with per-channel beat counters.
// Macro DEMUX_AUTO_SEL_EN: steer by internal round-robin pointer instead of sel.
module demux_1in_4out
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     I,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     Q,
    output logic [NCH-1:0]       q_valid,
    input  logic [NCH-1:0]       q_ready,
    output logic [NCH*CNT_W-1:0] cnt
);

    state_e               state_q;
    state_e               state_d;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     data_d;
    logic [NCH-1:0]       vld_q;
    logic [NCH-1:0]       vld_d;
    logic [NCH*CNT_W-1:0] cnt_q;
    logic [NCH*CNT_W-1:0] cnt_d;

    logic [NCH-1:0]       fire_ch;
    logic                 fire;
    logic                 take;
    logic [SEL_W-1:0]     dest;

    // Ready on a non-pending channel is masked out by vld_q.
    assign fire_ch  = vld_q & q_ready;
    assign fire     = |fire_ch;
    assign in_ready = (state_q == EMPTY) | fire;
    assign take     = in_valid & in_ready;

`ifdef DEMUX_AUTO_SEL_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             unused_sel;

    assign unused_sel = ^sel;

    demux_rr_ptr u_rr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (take),
        .ptr_o (rr_ptr)
    );

    assign dest = rr_ptr;
`else
    assign dest = sel;
`endif

    // State register; reset also drops any beat offered this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on accept, drain when the beat leaves with no refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (take) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (fire && !take) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Output register next values: load on accept, clear valid on drain.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (take) begin
            data_d = I;
            vld_d  = onehot4(dest);
        end else if (fire) begin
            vld_d  = '0;
        end
    end

    // Per-channel delivered-beat counters; overflow wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        for (int n = 0; n < NCH; n++) begin
            cnt_d[n*CNT_W +: CNT_W] =
                cnt_q[n*CNT_W +: CNT_W] + CNT_W'(fire_ch[n]);
        end
    end

    // Data, valid and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Q       = data_q;
    assign q_valid = vld_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_demux_1in_4out.sv
// Scoreboard bench for demux_1in_4out: directed scenarios plus random traffic.
// Expected beats are queued by the driver and retired by a negedge monitor.
module tb_demux_1in_4out;

    localparam int WIDTH = 1;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   I;
    logic [1:0]         sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   Q;
    logic [3:0]         q_valid;
    logic [3:0]         q_ready;
    logic [4*CNT_W-1:0] cnt;

    demux_1in_4out #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .I        (I),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Q        (Q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .cnt      (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [3:0]       oh;
    } beat_t;

    beat_t            sb[$];
    int               total = 0;
    int               bad   = 0;
    bit               started = 0;
    bit               flush = 0;

    // Reference model: one holding slot, counters, round-robin pointer.
    bit               m_full = 0;
    int               m_ch = 0;
    int               m_rr = 0;
    logic [CNT_W-1:0] m_cnt [4];
    logic             exp_ready;
    logic [3:0]       exp_shown;
    logic [4*CNT_W-1:0] exp_cnt;

    task automatic step(
        input logic             iv,
        input logic [1:0]       s,
        input logic [WIDTH-1:0] d,
        input logic [3:0]       qr,
        input logic             r
    );
        bit m_fire;
        bit acc;
        int dst;
        beat_t b;
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
            flush = 0;
        end
        exp_shown = m_full ? (4'b0001 << m_ch) : 4'b0000;
        for (int n = 0; n < 4; n++) begin
            exp_cnt[n*CNT_W +: CNT_W] = m_cnt[n];
        end
        started  = 1;
        in_valid = iv;
        sel      = s;
        I        = d;
        q_ready  = qr;
        rst      = r;
        m_fire    = m_full && qr[m_ch];
        exp_ready = !m_full || m_fire;
        if (r) begin
            m_full = 0;
            m_rr   = 0;
            flush  = 1;
            for (int n = 0; n < 4; n++) m_cnt[n] = '0;
        end else begin
            if (m_fire) m_cnt[m_ch] = m_cnt[m_ch] + 1'b1;
            acc = iv && exp_ready;
            if (acc) begin
`ifdef DEMUX_AUTO_SEL_EN
                dst  = m_rr;
                m_rr = (m_rr + 1) % 4;
`else
                dst  = int'(s);
`endif
                b.d  = d;
                b.oh = 4'b0001 << dst;
                sb.push_back(b);
                m_ch = dst;
            end
            m_full = acc || (m_full && !m_fire);
        end
    endtask

    task automatic idle(input int n, input logic [3:0] qr);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, '0, qr, 1'b0);
    endtask

    // Monitor: compare handshake, counters and pending beat every cycle.
    always @(negedge clk) begin
        if (started) begin
            total++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL in_ready got=%b want=%b t=%0t",
                         in_ready, exp_ready, $time);
            end
            total++;
            if (q_valid !== exp_shown) begin
                bad++;
                $display("FAIL q_valid got=%b want=%b t=%0t",
                         q_valid, exp_shown, $time);
            end
            total++;
            if (cnt !== exp_cnt) begin
                bad++;
                $display("FAIL cnt got=%h want=%h t=%0t",
                         cnt, exp_cnt, $time);
            end
            if (q_valid != 4'b0000) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL beat unexpected q_valid=%b t=%0t",
                             q_valid, $time);
                end else begin
                    if (Q !== sb[0].d || q_valid !== sb[0].oh) begin
                        bad++;
                        $display("FAIL beat got Q=%b v=%b want Q=%b v=%b t=%0t",
                                 Q, q_valid, sb[0].d, sb[0].oh, $time);
                    end
                    if (!rst && (q_valid & q_ready) != 4'b0000)
                        void'(sb.pop_front());
                end
            end
        end
    end

    task automatic check_eq(input string nm, input logic [31:0] got,
                            input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) m_cnt[n] = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        sel = 2'd0;
        I = '0;
        q_ready = 4'b0000;

        // Reset with a beat offered: must be dropped.
        step(1'b1, 2'd1, 1'b1, 4'b0000, 1'b1);
        step(1'b0, 2'd0, '0, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check_eq("rst_Q", 32'(Q), 32'd0);
        check_eq("rst_qv", 32'(q_valid), 32'd0);
        check_eq("rst_cnt", cnt, 32'd0);
        check_eq("rst_rdy", 32'(in_ready), 32'd1);

        // Single beat to channel 2, held, then released.
        step(1'b1, 2'd2, 1'b1, 4'b0000, 1'b0);
        idle(3, 4'b0000);
        idle(1, 4'b0100);
        idle(2, 4'b0000);

        // Back-to-back on all channels.
        for (int k = 0; k < 4; k++)
            step(1'b1, 2'(k), WIDTH'($urandom), 4'b1111, 1'b0);
        idle(2, 4'b1111);

        // Ready on the wrong channels only.
        step(1'b1, 2'd1, 1'b1, 4'b1101, 1'b0);
        idle(3, 4'b1101);
        idle(2, 4'b0010);

        // Reset while full, with the pending channel ready.
        step(1'b1, 2'd3, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 2'd0, '0, 4'b1000, 1'b1);
        idle(2, 4'b1111);

        // Counter wrap: 256 fires on channel 3.
        for (int k = 0; k < 256; k++)
            step(1'b1, 2'd3, WIDTH'($urandom), 4'b1111, 1'b0);
        idle(2, 4'b1111);
        @(negedge clk);
        #1;
        check_eq("wrap_cnt3", 32'(cnt[3*CNT_W +: CNT_W]), 32'(m_cnt[3]));

        // Five beats with sel held at 0.
        step(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++)
            step(1'b1, 2'd0, WIDTH'($urandom), 4'b1111, 1'b0);
        idle(2, 4'b1111);

        // Random traffic with occasional reset.
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) != 0, 2'($urandom),
                 WIDTH'($urandom), 4'($urandom),
                 $urandom_range(0, 199) == 0);
        idle(3, 4'b1111);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
